// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light timing stage: RAG phase codes,
// FSM state encoding and small helpers used by the top and the testbench.
package traffic_pkg;

    localparam logic [2:0] PH_RED       = 3'b100;
    localparam logic [2:0] PH_RED_AMBER = 3'b110;
    localparam logic [2:0] PH_GREEN     = 3'b001;
    localparam logic [2:0] PH_AMBER     = 3'b010;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_COUNT,
        ST_WALK,
        ST_STEP,
        ST_WAIT
    } state_t;

    // True for the four codes the sequencer is allowed to present.
    function automatic logic phase_legal(input logic [2:0] ph);
        return (ph == PH_RED) || (ph == PH_RED_AMBER) ||
               (ph == PH_GREEN) || (ph == PH_AMBER);
    endfunction

    // A dwell of zero cycles makes no sense for a lamp; treat it as one.
    function automatic int clamp_dwell(input int cyc);
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/traffic_down_counter.sv
// Load / decrement / zero-flag counter shared by the dwell timer and the
// optional WAIT watchdog. Decrement saturates at zero so it never wraps.
module traffic_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority over decrement; hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_step_gen.sv
// Timing stage feeding the UK traffic-light sequencer. Decodes the RAG
// lamps, holds each phase for its dwell, then issues a one-cycle step
// (the sequencer's clock enable). Pedestrian requests extend red with a
// walk interval. Define TRAFFIC_WATCHDOG_EN to add a WAIT watchdog that
// re-issues step and raises a sticky fault when the sequencer is stuck.
//
// state | meaning
// SYNC  | after reset: adopt the current phase, or step if illegal
// COUNT | phase dwell running
// WALK  | walk lamp on, red extended
// STEP  | step high for this single cycle
// WAIT  | waiting for the sequencer to show a new phase
module traffic_step_gen
    import traffic_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int RED_CYC  = 8,
    parameter int RA_CYC   = 2,
    parameter int GRN_CYC  = 10,
    parameter int AMB_CYC  = 3,
    parameter int WALK_CYC = 6,
    parameter int WD_CYC   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic red,
    input  logic amber,
    input  logic green,
    input  logic ped_req,
    output logic step,
    output logic walk,
    output logic ped_ack,
    output logic fault
);

    // Counter load values are dwell-1: the load cycle itself counts.
    localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(clamp_dwell(RED_CYC) - 1);
    localparam logic [CNT_W-1:0] RA_LD   = CNT_W'(clamp_dwell(RA_CYC) - 1);
    localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(clamp_dwell(GRN_CYC) - 1);
    localparam logic [CNT_W-1:0] AMB_LD  = CNT_W'(clamp_dwell(AMB_CYC) - 1);
    localparam logic [CNT_W-1:0] WALK_LD = CNT_W'(clamp_dwell(WALK_CYC) - 1);

    function automatic logic [CNT_W-1:0] dwell_ld(input logic [2:0] ph);
        case (ph)
            PH_RED_AMBER: return RA_LD;
            PH_GREEN:     return GRN_LD;
            PH_AMBER:     return AMB_LD;
            default:      return RED_LD;
        endcase
    endfunction

    state_t           state_q;
    logic [2:0]       phase_q;
    logic             ped_pending_q;
    logic             step_q;
    logic             walk_q;
    logic             ped_ack_q;
    logic             fault_q;

    logic [2:0]       phase_now;
    logic             legal_now;
    logic             dwell_zero;
    logic             walk_entry;
    logic             wd_expire;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;

    assign phase_now  = {red, amber, green};
    assign legal_now  = phase_legal(phase_now);
    assign walk_entry = (state_q == ST_COUNT) && dwell_zero &&
                        (phase_q == PH_RED) && ped_pending_q;

    // Dwell counter control, mirroring the FSM transitions that load it.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = dwell_ld(phase_now);
        cnt_dec      = (state_q == ST_COUNT) || (state_q == ST_WALK);
        if ((state_q == ST_SYNC) && legal_now) begin
            cnt_load = 1'b1;
        end else if (walk_entry) begin
            cnt_load     = 1'b1;
            cnt_load_val = WALK_LD;
        end else if ((state_q == ST_WAIT) && legal_now && (phase_now != phase_q)) begin
            cnt_load = 1'b1;
        end
    end

    traffic_down_counter #(.CNT_W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (dwell_zero)
    );

`ifdef TRAFFIC_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WD_LD = CNT_W'(clamp_dwell(WD_CYC) - 1);

    // WAIT is always entered from STEP, so reload the watchdog there.
    traffic_down_counter #(.CNT_W(CNT_W)) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == ST_STEP),
        .load_val_i (WD_LD),
        .dec_i      (state_q == ST_WAIT),
        .zero_o     (wd_expire)
    );
`else
    logic wd_cfg_unused;
    assign wd_cfg_unused = (WD_CYC == 0);
    assign wd_expire     = 1'b0;
`endif

    // Sequencing FSM with registered step/walk/ped_ack/fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            phase_q       <= 3'b000;
            ped_pending_q <= 1'b0;
            step_q        <= 1'b0;
            walk_q        <= 1'b0;
            ped_ack_q     <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            step_q    <= 1'b0;
            ped_ack_q <= 1'b0;
            if (walk_entry) begin
                ped_pending_q <= 1'b0;
            end else if (ped_req && (state_q != ST_WALK)) begin
                ped_pending_q <= 1'b1;
            end
            case (state_q)
                ST_SYNC: begin
                    if (legal_now) begin
                        phase_q <= phase_now;
                        state_q <= ST_COUNT;
                    end else begin
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (walk_entry) begin
                        state_q   <= ST_WALK;
                        walk_q    <= 1'b1;
                        ped_ack_q <= 1'b1;
                    end else if (dwell_zero) begin
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end
                end
                ST_WALK: begin
                    if (dwell_zero) begin
                        walk_q  <= 1'b0;
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!legal_now) begin
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end else if (phase_now != phase_q) begin
                        phase_q <= phase_now;
                        state_q <= ST_COUNT;
                    end else if (wd_expire) begin
                        fault_q <= 1'b1;
                        state_q <= ST_STEP;
                        step_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_SYNC;
                end
            endcase
        end
    end

    assign step    = step_q;
    assign walk    = walk_q;
    assign ped_ack = ped_ack_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_traffic_step_gen.sv
// Bench for traffic_step_gen: a sequencer model advances on step; the
// stimulus queues the expected shape of every phase segment (from one step
// to the next) and a monitor measures each segment and compares on step.
module tb_traffic_step_gen;

    localparam logic [2:0] P_R   = 3'b100;
    localparam logic [2:0] P_RA  = 3'b110;
    localparam logic [2:0] P_G   = 3'b001;
    localparam logic [2:0] P_A   = 3'b010;
    localparam logic [2:0] P_ILL = 3'b111;

    typedef struct {
        logic [2:0] ph;
        int         len;
        int         walk_cyc;
        int         walk_off;
        int         ack_cyc;
        int         ack_off;
        logic       flt;
    } seg_t;

    seg_t exp_q[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic red, amber, green;
    logic ped_req = 1'b0;
    logic step, walk, ped_ack, fault;

    logic [2:0] ph_m = P_R;
    logic       ignore_step = 1'b0;
    logic       force_ill = 1'b0;

    int checks = 0;
    int failures = 0;
    int seg_done = 0;
    int final_seg = 0;

    int seg_len = 0, walk_cnt = 0, walk_first = 0, ack_cnt = 0, ack_first = 0;
    logic prev_step = 1'b0;

    assign {red, amber, green} = ph_m;

    always #5 clk = ~clk;

    traffic_step_gen dut (
        .clk     (clk),
        .rst     (rst),
        .red     (red),
        .amber   (amber),
        .green   (green),
        .ped_req (ped_req),
        .step    (step),
        .walk    (walk),
        .ped_ack (ped_ack),
        .fault   (fault)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [2:0] ph, input int len, input int wc,
                        input int wo, input logic flt);
        seg_t s;
        s.ph       = ph;
        s.len      = len;
        s.walk_cyc = wc;
        s.walk_off = wo;
        s.ack_cyc  = (wc > 0) ? 1 : 0;
        s.ack_off  = wo;
        s.flt      = flt;
        exp_q.push_back(s);
    endtask

    task automatic wait_seg(input int n);
        int k = 0;
        while ((seg_done < n) && (k < 3000)) begin
            @(negedge clk); #1;
            k++;
        end
        chk($sformatf("wait_seg%0d_reached", n), int'(seg_done >= n), 1);
    endtask

    task automatic wait_phase(input logic [2:0] ph);
        int k = 0;
        while ((ph_m != ph) && (k < 200)) begin
            @(negedge clk); #1;
            k++;
        end
        chk("wait_phase_reached", int'(ph_m), int'(ph));
    endtask

    task automatic pulse_ped();
        ped_req = 1'b1;
        @(negedge clk); #1;
        ped_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_step", int'(step), 0);
        chk("rst_async_walk", int'(walk), 0);
        chk("rst_async_ped_ack", int'(ped_ack), 0);
        chk("rst_async_fault", int'(fault), 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    // Sequencer model: advances on the edge after a step cycle.
    initial begin : seq_model
        logic adv;
        forever begin
            @(negedge clk);
            adv = step && !ignore_step;
            @(posedge clk);
            #1;
            if (adv) begin
                case (ph_m)
                    P_R:  ph_m = P_RA;
                    P_RA: ph_m = P_G;
                    P_G: begin
                        if (force_ill) begin
                            ph_m      = P_ILL;
                            force_ill = 1'b0;
                        end else begin
                            ph_m = P_A;
                        end
                    end
                    default: ph_m = P_R;
                endcase
            end
        end
    end

    // Monitor: measures each segment and compares on its step cycle.
    initial begin : monitor
        seg_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                seg_len = 0; walk_cnt = 0; walk_first = 0;
                ack_cnt = 0; ack_first = 0; prev_step = 1'b0;
            end else begin
                seg_len++;
                if (walk) begin
                    walk_cnt++;
                    if (walk_first == 0) walk_first = seg_len;
                end
                if (ped_ack) begin
                    ack_cnt++;
                    if (ack_first == 0) ack_first = seg_len;
                end
                if (step) begin
                    chk("step_single_cycle", int'(prev_step), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_step", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("seg%0d_phase", seg_done + 1), int'({red, amber, green}), int'(e.ph));
                        chk($sformatf("seg%0d_len", seg_done + 1), seg_len, e.len);
                        chk($sformatf("seg%0d_walk_cyc", seg_done + 1), walk_cnt, e.walk_cyc);
                        chk($sformatf("seg%0d_walk_off", seg_done + 1), walk_first, e.walk_off);
                        chk($sformatf("seg%0d_ack_cyc", seg_done + 1), ack_cnt, e.ack_cyc);
                        chk($sformatf("seg%0d_ack_off", seg_done + 1), ack_first, e.ack_off);
                        chk($sformatf("seg%0d_fault", seg_done + 1), int'(fault), int'(e.flt));
                    end
                    seg_done++;
                    seg_len = 0; walk_cnt = 0; walk_first = 0;
                    ack_cnt = 0; ack_first = 0;
                end
                prev_step = step;
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout seg_done=%0d", seg_done);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #2;
        chk("reset_step", int'(step), 0);
        chk("reset_walk", int'(walk), 0);
        chk("reset_ped_ack", int'(ped_ack), 0);
        chk("reset_fault", int'(fault), 0);

        // Free-running cadence from RED, then a pulse request during green.
        push(P_R, 10, 0, 0, 1'b0);
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        push(P_R, 10, 0, 0, 1'b0);
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        push(P_R, 16, 6, 10, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        wait_seg(6);
        wait_phase(P_G);
        pulse_ped();

        // Request held 20 cycles from amber start through the walk.
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        push(P_R, 16, 6, 10, 1'b0);
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        push(P_R, 10, 0, 0, 1'b0);
        wait_seg(11);
        wait_phase(P_A);
        ped_req = 1'b1;
        repeat (20) begin
            @(negedge clk); #1;
        end
        ped_req = 1'b0;

        // Sequencer jumps to 111 after green; recovers to RED.
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
        push(P_ILL, 2, 0, 0, 1'b0);
        push(P_R, 10, 0, 0, 1'b0);
        push(P_RA, 4, 0, 0, 1'b0);
        wait_seg(18);
        force_ill = 1'b1;

        // Reset on the first walk cycle of the next red.
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        wait_seg(22);
        wait_phase(P_G);
        pulse_ped();
        wait_seg(24);
        begin
            int k = 0;
            while (!walk && (k < 100)) begin
                @(negedge clk); #1;
                k++;
            end
        end
        chk("pre_rst_walk", int'(walk), 1);
        chk("pre_rst_ped_ack", int'(ped_ack), 1);
        pulse_reset();

        // After reset: SYNC reloads red; then the sequencer stops obeying step.
        push(P_R, 10, 0, 0, 1'b0);
        push(P_RA, 4, 0, 0, 1'b0);
        push(P_G, 12, 0, 0, 1'b0);
`ifdef TRAFFIC_WATCHDOG_EN
        push(P_G, 5, 0, 0, 1'b1);
        push(P_G, 5, 0, 0, 1'b1);
        push(P_G, 5, 0, 0, 1'b1);
        wait_seg(26);
        ignore_step = 1'b1;
        wait_seg(30);
        chk("fault_sticky", int'(fault), 1);
        final_seg = 32;
`else
        wait_seg(26);
        ignore_step = 1'b1;
        wait_seg(27);
        repeat (30) @(negedge clk);
        #1;
        chk("no_step_while_stuck", seg_done, 27);
        chk("fault_tied_low", int'(fault), 0);
        final_seg = 29;
`endif
        pulse_reset();
        ignore_step = 1'b0;
        push(P_G, 12, 0, 0, 1'b0);
        push(P_A, 5, 0, 0, 1'b0);
        wait_seg(final_seg);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
